// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts 32-bit words and writes them into memory as little-endian bytes.
// Optional running word checksum is enabled with `define INSTR_MEM_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int MEM_BYTES = 76,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              wr_valid,
  input  logic [31:0]       wr_word,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_byte,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [31:0]       word_reg, word_next;
  logic              last_reg, last_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic              overflow_reg, overflow_next;
  logic              word_fits;
  logic              transfer;

  // One extra bit so a base near the top of the address space cannot wrap past the limit.
  assign word_fits = ({1'b0, base_reg} + (ADDR_W+1)'(4)) <= (ADDR_W+1)'(MEM_BYTES);
  assign transfer  = wr_valid && wr_ready;
  assign busy      = (state_reg != IDLE);
  assign overflow  = overflow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      word_reg     <= '0;
      last_reg     <= 1'b0;
      byte_idx_reg <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      word_reg     <= word_next;
      last_reg     <= last_next;
      byte_idx_reg <= byte_idx_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    word_next     = word_reg;
    last_next     = last_reg;
    byte_idx_next = byte_idx_reg;
    overflow_next = overflow_reg;
    wr_ready      = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_byte      = '0;
    load_done     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_start) begin
          state_next    = ACCEPT;
          base_next     = start_addr;
          overflow_next = 1'b0;
        end
      end

      ACCEPT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          if (word_fits) begin
            word_next     = wr_word;
            last_next     = wr_last;
            byte_idx_next = 2'd0;
            state_next    = WRITE;
          end else begin
            // Out-of-range word is dropped and the session is closed.
            overflow_next = 1'b1;
            state_next    = DONE;
          end
        end
      end

      WRITE: begin
        mem_we        = 1'b1;
        mem_addr      = base_reg + {{(ADDR_W-2){1'b0}}, byte_idx_reg};
        mem_byte      = word_reg[{byte_idx_reg, 3'b000} +: 8];
        byte_idx_next = byte_idx_reg + 2'd1;
        if (byte_idx_reg == 2'd3) begin
          base_next  = base_reg + ADDR_W'(4);
          state_next = last_reg ? DONE : ACCEPT;
        end
      end

      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_reg <= '0;
    end else if ((state_reg == IDLE) && load_start) begin
      checksum_reg <= '0;
    end else if (transfer && word_fits) begin
      checksum_reg <= checksum_reg + wr_word;
    end
  end

  assign checksum = checksum_reg;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
  assign checksum        = '0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader; expected memory image, flags and
// checksum are computed from the word stream with plain arithmetic.
module tb_instr_mem_loader;

  localparam int MEM_BYTES = 76;
  localparam int ADDR_W    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_word = '0;
  logic              wr_last = 1'b0;
  logic              wr_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_byte;
  logic              busy;
  logic              load_done;
  logic              overflow;
  logic [31:0]       checksum;

  instr_mem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .start_addr (start_addr),
    .wr_valid   (wr_valid),
    .wr_word    (wr_word),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byte   (mem_byte),
    .busy       (busy),
    .load_done  (load_done),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_mem [MEM_BYTES];
  logic [7:0] act_mem [MEM_BYTES];
  bit         exp_wr  [MEM_BYTES];
  bit         act_wr  [MEM_BYTES];
  int         oob_writes = 0;
  int         we_count = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cksum(input logic [31:0] sum);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    return sum;
`else
    return 32'h0 & sum;
`endif
  endfunction

  // Memory-side observer: records every byte the DUT writes.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      if (mem_addr < MEM_BYTES) begin
        act_mem[int'(mem_addr)] = mem_byte;
        act_wr[int'(mem_addr)]  = 1'b1;
      end else begin
        oob_writes++;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < MEM_BYTES; i++) begin
      exp_mem[i] = '0;
      act_mem[i] = '0;
      exp_wr[i]  = 1'b0;
      act_wr[i]  = 1'b0;
    end
    oob_writes = 0;
  endtask

  function automatic int image_errors();
    int bad = oob_writes;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (exp_wr[i] != act_wr[i]) bad++;
      else if (exp_wr[i] && (exp_mem[i] != act_mem[i])) bad++;
    end
    return bad;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_byte"}, mem_byte, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  // One load session: n words from sa, gap idle cycles before each word.
  task automatic session(input longint unsigned sa, input int n, input int gap,
                         input bit pulse_mid, input logic [31:0] w0);
    longint unsigned base;
    logic [31:0]     w;
    logic [31:0]     sum;
    bit              ovf;
    clear_model();
    base = sa;
    sum  = '0;
    ovf  = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b1;
    start_addr = sa;
    @(posedge clk); #1;
    load_start = 1'b0;
    start_addr = {$urandom, $urandom};
    for (int k = 0; k < n && !ovf; k++) begin
      w = (k == 0 && w0 != 0) ? w0 : $urandom;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_ready", wr_ready, 1);
        check("gap_we", mem_we, 0);
        check("gap_busy", busy, 1);
        @(posedge clk); #1;
      end
      wr_valid = 1'b1;
      wr_word  = w;
      wr_last  = (k == n - 1);
      @(negedge clk);
      check("accept_ready", wr_ready, 1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      wr_word  = $urandom;
      if (base + 4 > MEM_BYTES) begin
        ovf = 1'b1;
        $display("[TB] word addr=%0d data=%08h rejected", base, w);
        @(negedge clk);
        check("ovf_no_we", mem_we, 0);
        check("ovf_done", load_done, 1);
        check("ovf_flag", overflow, 1);
      end else begin
        $display("[TB] word addr=%0d data=%08h last=%0b", base, w, (k == n - 1));
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("wr_we", mem_we, 1);
          check("wr_ready_low", wr_ready, 0);
          check("wr_addr", mem_addr, base + i);
          check("wr_byte", mem_byte, (w >> (8 * i)) & 32'hff);
          exp_mem[int'(base) + i] = 8'((w >> (8 * i)) & 32'hff);
          exp_wr[int'(base) + i]  = 1'b1;
          if (pulse_mid && k == 0 && i == 0) begin
            load_start = 1'b1;
            start_addr = 64'd40;
          end
          @(posedge clk); #1;
          load_start = 1'b0;
        end
        sum  = sum + w;
        base = base + 4;
        if (k == n - 1) begin
          @(negedge clk);
          check("done_pulse", load_done, 1);
          check("done_no_we", mem_we, 0);
        end
      end
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done_low", load_done, 0);
    check("idle_ready", wr_ready, 0);
    check("idle_overflow", overflow, ovf);
    check("idle_checksum", checksum, exp_cksum(sum));
    check("mem_image", image_errors(), 0);
  endtask

  task automatic reset_mid_write();
    int saved;
    clear_model();
    @(posedge clk); #1;
    load_start = 1'b1;
    start_addr = '0;
    @(posedge clk); #1;
    load_start = 1'b0;
    wr_valid   = 1'b1;
    wr_word    = 32'hdeadbeef;
    wr_last    = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    @(negedge clk);
    check("rst_b0_we", mem_we, 1);
    @(negedge clk);
    check("rst_b1_addr", mem_addr, 1);
    #2 reset = 1'b0;
    #1;
    $display("[TB] reset asserted mid-write");
    check_zero("rst_mid");
    saved = we_count;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_resume", we_count - saved, 0);
    check("rst_idle_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    session(0, 1, 0, 1'b0, 32'h00a00f93);
    session(0, 19, 0, 1'b0, 32'h0);
    session(72, 2, 1, 1'b0, 32'h0);
    session(4, 2, 3, 1'b0, 32'h0);
    reset_mid_write();
    session(8, 2, 0, 1'b0, 32'h0);
    session(16, 3, 0, 1'b1, 32'h0);
    session(70, 3, 0, 1'b0, 32'h0);
    for (int r = 0; r < 12; r++) begin
      session($urandom_range(0, MEM_BYTES + 3), $urandom_range(1, 6),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 76, instruction memory depth in bytes.
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_start, input, 1, a one-cycle pulse that begins a load session; honoured only in IDLE.
REQ-006 SHALL have port start_addr, input, ADDR_W, first byte address, sampled with load_start.
REQ-007 SHALL have port wr_valid, input, 1, word offered.
REQ-008 SHALL have port wr_word, input, 32, instruction word.
REQ-009 SHALL have port wr_last, input, 1, marks the final word of the session; qualified by wr_valid.
REQ-010 SHALL have port wr_ready, output, 1, loader accepts a word this cycle.
REQ-011 SHALL have port mem_we, output, 1, byte write strobe to instruction memory.
REQ-012 SHALL have port mem_addr, output, ADDR_W, byte address of the write.
REQ-013 SHALL have port mem_byte, output, 8, byte data of the write.
REQ-014 SHALL have port busy, output, 1, session active (any state except IDLE).
REQ-015 SHALL have port load_done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port overflow, output, 1, sticky out-of-range flag.
REQ-017 SHALL have port checksum, output, 32, running word sum (see Configuration).

Function
REQ-018 SHALL implement the states IDLE, ACCEPT, WRITE and DONE.
REQ-019 IDLE SHALL move to ACCEPT on load_start, set base to start_addr and clear overflow and checksum.
REQ-020 ACCEPT SHALL drive wr_ready=1; a transfer SHALL occur only when wr_valid and wr_ready are both 1.
REQ-021 On a transfer, the loader SHALL capture wr_word and wr_last, set byte_idx=0 and move to WRITE.
REQ-022 WRITE SHALL drive wr_ready=0 and mem_we=1 for exactly 4 consecutive cycles.
REQ-023 In each WRITE cycle, mem_addr SHALL be base+byte_idx and mem_byte SHALL be word[8*byte_idx+7 : 8*byte_idx], giving little-endian order (byte 0 = bits 7:0 at the lowest address).
REQ-024 After the byte_idx=3 cycle, base SHALL advance by 4 and the state SHALL move to DONE if the captured last flag is set, else to ACCEPT.
REQ-025 Throughput SHALL be one word per 5 cycles (1 accept cycle + 4 write cycles); the first write SHALL occur on the cycle after acceptance.
REQ-026 DONE SHALL assert load_done for one cycle and then return to IDLE.
REQ-027 If a transfer occurs with base+4 > MEM_BYTES, the loader SHALL NOT write the word, SHALL set overflow and SHALL go to DONE.
REQ-028 overflow SHALL hold its value until the next load_start.
REQ-029 load_start outside IDLE SHALL be ignored.
REQ-030 mem_we SHALL be 0 in IDLE, ACCEPT and DONE, with mem_addr and mem_byte at 0 in those states.
REQ-031 Address arithmetic SHALL be unsigned ADDR_W bits; start_addr need not be word-aligned.

Reset
REQ-032 Reset assertion SHALL immediately force IDLE and drive all outputs to 0: wr_ready, mem_we, mem_addr, mem_byte, busy, load_done, overflow, checksum.
REQ-033 Reset asserted mid-WRITE SHALL suppress the remaining byte writes; no partial-word resumption after release.
REQ-034 Release of reset SHALL take effect on the next rising clk edge.

Configuration
REQ-035 With macro INSTR_MEM_LOADER_CHECKSUM_EN defined, checksum SHALL add each accepted, non-overflowing wr_word modulo 2^32 in the cycle after acceptance and SHALL hold its value through DONE and IDLE.
REQ-036 Without INSTR_MEM_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-037 Reset, start_addr=0, single word 32'h00a00f93 with wr_last=1 -> writes 93,0f,a0,00 to addresses 0..3 on consecutive cycles, load_done one cycle later, checksum=32'h00a00f93.
REQ-038 19 words from address 0 with wr_last on word 19 -> 76 byte writes, final write at address 75, overflow=0.
REQ-039 start_addr=72, two words -> first word written at 72..75, second rejected with no mem_we, overflow=1, load_done pulses.
REQ-040 wr_valid held low for 3 cycles in ACCEPT -> wr_ready stays 1, mem_we stays 0, no state change.
REQ-041 Reset asserted after the second byte of a word -> mem_we=0 immediately, busy=0, and a fresh session from address 8 writes correctly.
REQ-042 load_start pulsed during WRITE -> ignored; base is unchanged and the session completes normally.
